// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the timing generator and the renderer
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           enable;
    logic           vga_clk;
    logic           pix_en;
    logic           hsync;
    logic           vsync;
    logic           blank;
    logic [X_W-1:0] pixel_x;
    logic [Y_W-1:0] pixel_y;
    logic           line_start;
    logic           frame_start;
    logic [7:0]     frame_count;

    modport master (
        input  enable,
        output vga_clk, pix_en, hsync, vsync, blank,
        output pixel_x, pixel_y, line_start, frame_start, frame_count
    );

    modport slave (
        output enable,
        input  vga_clk, pix_en, hsync, vsync, blank,
        input  pixel_x, pixel_y, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int X_W       = 10,
    parameter int Y_W       = 10
) (
    input  logic            clock,
    input  logic            reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [X_W-1:0]   h_cnt;
    logic [X_W-1:0]   h_next;
    logic [Y_W-1:0]   v_cnt;
    logic [Y_W-1:0]   v_next;
    logic [7:0]       frame_cnt;
    logic             tick;
    logic             h_wrap;
    logic             frame_wrap;
    int               h_next_i;
    int               v_next_i;

    // Next-state of the divider and raster counters; outputs decode these post-update values
    always_comb begin
        tick       = 1'b0;
        div_next   = div_cnt;
        h_wrap     = (h_cnt == H_LAST);
        h_next     = h_cnt;
        v_next     = v_cnt;
        frame_wrap = 1'b0;
        if (vga.enable) begin
            tick     = (div_cnt == DIV_LAST);
            div_next = tick ? '0 : div_cnt + 1'b1;
        end
        if (h_wrap) begin
            h_next = '0;
            if (v_cnt == V_LAST) begin
                v_next     = '0;
                frame_wrap = 1'b1;
            end else begin
                v_next = v_cnt + 1'b1;
            end
        end else begin
            h_next = h_cnt + 1'b1;
        end
        h_next_i = int'(h_next);
        v_next_i = int'(v_next);
    end

    // Divider and raster counters; the raster only moves on a pixel tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
        end else begin
            div_cnt <= div_next;
            if (tick) begin
                h_cnt <= h_next;
                v_cnt <= v_next;
                if (frame_wrap) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // Registered sync/blank/strobe outputs, updated alongside the counters they describe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga.vga_clk     <= 1'b0;
            vga.pix_en      <= 1'b0;
            vga.hsync       <= ~HSYNC_POL;
            vga.vsync       <= ~VSYNC_POL;
            vga.blank       <= 1'b1;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.pix_en      <= tick;
            vga.line_start  <= tick && (h_next == '0);
            vga.frame_start <= tick && (h_next == '0) && (v_next == '0);
            if (vga.enable) begin
                vga.vga_clk <= (div_next >= DIV_HALF);
            end
            if (tick) begin
                vga.blank <= !((h_next_i < H_ACTIVE) && (v_next_i < V_ACTIVE));
                vga.hsync <= ((h_next_i >= HS_START) && (h_next_i < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
                vga.vsync <= ((v_next_i >= VS_START) && (v_next_i < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

    assign vga.pixel_x     = h_cnt;
    assign vga.pixel_y     = v_cnt;
    assign vga.frame_count = frame_cnt;
endmodule
